rtc_sequencer: RTL and testbench
================================

RTC_SEQUENCER -- requirements
Module: rtc_sequencer

Interface
REQ-001 Parameters SHALL be: NCH, default 3, number of programmable channels (hour, date, timer); POLL_DIV, default 1024, cycles between periodic RTC reads; CFG_W, default 2, width of the watched configuration vector; TIMEOUT, default 255, bus-ack watchdog limit in cycles.
REQ-002 Ports SHALL be, clock and reset first:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-low.
- prog_req  in  NCH  per-channel program request; level, held while the user edits.
- cfg_vec  in  CFG_W  format/timer-start settings, watched for change.
- timer_done  in  1  timer reached its programmed limit.
- timer_run  in  1  timer alarm active.
- bus_ack  in  1  RTC bus engine finished the current op.
- bus_req  out  1  op request to the RTC bus engine.
- bus_op  out  2  op code: READ, INIT, WRITE, TRESTART.
- bus_ch  out  CHW  target channel, CHW = max(1, clog2(NCH)).
- edit_en  out  NCH  one-hot edit enable for the channel being edited.
- lock  out  1  programming session open.
- read_valid  out  1  one-cycle pulse when a READ completes.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky bus-timeout flag.

Function
REQ-003 The FSM SHALL have states IDLE, READ, CHECK, INIT, TRESTART, EDIT and SAVE.
REQ-004 The sub-module SHALL issue a poll tick every POLL_DIV cycles. A tick arriving outside IDLE SHALL be held in a one-deep pending flag. IDLE SHALL go to READ on a tick or on a pending flag.
REQ-005 Bus handshake:
- bus_req, bus_op and bus_ch SHALL be driven and held stable from state entry until bus_ack is sampled high.
- bus_req SHALL be low on the cycle after the ack.
- bus_ack SHALL be ignored while bus_req is low.
REQ-006 READ: bus_op=READ. On ack, read_valid SHALL pulse for one cycle and the FSM SHALL go to CHECK.
REQ-007 CHECK SHALL evaluate in strict priority, in a single cycle:
- (a) cfg_vec differs from cfg_q, or timer_done rose since the last CHECK -> INIT; cfg_q and the timer_done reference SHALL be updated.
- (b) any prog_req bit set and lock=0 -> INIT, and lock SHALL be set to 1.
- (c) timer_done=1 and timer_run=0 -> TRESTART.
- (d) lock=1 and a prog_req bit set -> EDIT; the lowest set index is captured into ch_q and edit_en[ch_q] is set.
- (e) none of the above -> IDLE.
REQ-008 INIT and TRESTART SHALL perform a single bus op each, then return to READ (re-read after any modification).
REQ-009 EDIT SHALL hold edit_en[ch_q] until prog_req[ch_q]=0, then go to SAVE. Requests on other channels SHALL be ignored while in EDIT.
REQ-010 SAVE: bus_op=WRITE, bus_ch=ch_q. On ack, edit_en SHALL clear, lock SHALL clear, and the FSM SHALL go to READ.
REQ-011 If lock=1 and all prog_req bits drop before EDIT is entered, the next CHECK SHALL clear lock and go to IDLE.
REQ-012 Poll counter wrap SHALL be modulo POLL_DIV, with no drift across pending ticks.

Reset
REQ-013 reset=0 sampled on a clock edge SHALL force IDLE and clear every output, cfg_q, ch_q, the pending flag and the counters. This SHALL also take effect mid-transaction: bus_req SHALL be low on the next cycle.
REQ-014 cfg_q SHALL reset to zero, so a nonzero cfg_vec triggers INIT on the first CHECK.

Configuration
REQ-015 With RTC_SEQ_TIMEOUT_EN defined:
- a counter SHALL run while bus_req=1;
- reaching TIMEOUT without an ack SHALL drop bus_req, set err (cleared only by reset), clear edit_en and lock, and go to IDLE.
REQ-016 Without RTC_SEQ_TIMEOUT_EN, the handshake SHALL wait indefinitely, err SHALL be tied to 0, and no watchdog logic SHALL be built.

Structure
REQ-017 Package rtc_seq_pkg SHALL hold the state enum, the bus_op codes (READ=0, INIT=1, WRITE=2, TRESTART=3) and the CHW helper function.
REQ-018 The poll divider SHALL be the sub-module rtc_seq_tick: parameter POLL_DIV, output tick.

Verification
REQ-019 Reset release, POLL_DIV=16, bus_ack returned 2 cycles after bus_req -> first bus_req with op READ at cycle 16, read_valid pulse, then IDLE.
REQ-020 cfg_vec 0->2 -> after the next READ: INIT op, then a second READ, then IDLE; no second INIT.
REQ-021 prog_req=3'b110 -> INIT with lock=1, READ, then EDIT with edit_en=3'b010; dropping prog_req[1] -> WRITE with bus_ch=1, lock=0, then READ.
REQ-022 timer_done=1 with timer_run=0 -> INIT (rise) -> READ -> TRESTART op on the following CHECK.
REQ-023 reset asserted while bus_req=1 in SAVE -> bus_req=0, lock=0, edit_en=0 on the next cycle.
REQ-024 RTC_SEQ_TIMEOUT_EN defined, TIMEOUT=8, bus_ack never asserted -> bus_req drops after 8 cycles, err=1, FSM in IDLE.

Source files
------------

// File: rtl/rtc_seq_pkg.sv
// Shared types for the RTC sequencer: FSM states, bus op codes and the channel-width helper.
package rtc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_CHECK    = 3'd2,
    ST_INIT     = 3'd3,
    ST_TRESTART = 3'd4,
    ST_EDIT     = 3'd5,
    ST_SAVE     = 3'd6
  } state_t;

  localparam logic [1:0] OP_READ     = 2'd0;
  localparam logic [1:0] OP_INIT     = 2'd1;
  localparam logic [1:0] OP_WRITE    = 2'd2;
  localparam logic [1:0] OP_TRESTART = 2'd3;

  // Channel index width, never narrower than one bit.
  function automatic int chw(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rtc_seq_tick.sv
// Free-running poll divider: tick is high for one cycle out of every POLL_DIV.
module rtc_seq_tick
  import rtc_seq_pkg::*;
#(
  parameter int POLL_DIV = 1024
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(POLL_DIV - 1);

  logic [PW-1:0] r_cnt;

  // Modulo counter; wraps on its own so pending ticks never shift the phase.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PW'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/rtc_sequencer.sv
// RTC access sequencer: periodic reads, re-init on config/timer change, channel edit sessions.
// Optional bus-ack watchdog built when RTC_SEQ_TIMEOUT_EN is defined.
module rtc_sequencer
  import rtc_seq_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int POLL_DIV = 1024,
  parameter int CFG_W    = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NCH-1:0]        prog_req,
  input  logic [CFG_W-1:0]      cfg_vec,
  input  logic                  timer_done,
  input  logic                  timer_run,
  input  logic                  bus_ack,
  output logic                  bus_req,
  output logic [1:0]            bus_op,
  output logic [chw(NCH)-1:0]   bus_ch,
  output logic [NCH-1:0]        edit_en,
  output logic                  lock,
  output logic                  read_valid,
  output logic                  busy,
  output logic                  err
);

  localparam int CHW = chw(NCH);

  state_t           r_state, w_state_nxt;
  logic             r_bus_req, w_bus_req_nxt;
  logic [1:0]       r_bus_op, w_bus_op_nxt;
  logic [CHW-1:0]   r_bus_ch, w_bus_ch_nxt;
  logic [NCH-1:0]   r_edit_en, w_edit_en_nxt;
  logic             r_lock, w_lock_nxt;
  logic             r_read_valid, w_read_valid_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_pend, w_pend_nxt;
  logic [CFG_W-1:0] r_cfg_q, w_cfg_q_nxt;
  logic             r_td_ref, w_td_ref_nxt;
  logic [CHW-1:0]   r_ch_q, w_ch_q_nxt;
  logic             w_tick, w_ack, w_timeout, w_prog_any, w_bus_state;
  logic [NCH-1:0]   w_low_oh;
  logic [CHW-1:0]   w_low_ch;

  rtc_seq_tick #(.POLL_DIV(POLL_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_ack      = r_bus_req & bus_ack;
  assign w_prog_any = |prog_req;

  // Lowest requesting channel as one-hot and as index.
  always_comb begin
    w_low_oh = prog_req & (~prog_req + NCH'(1));
    w_low_ch = '0;
    for (int i = 0; i < NCH; i++) begin
      w_low_ch = w_low_ch | (CHW'(i) & {CHW{w_low_oh[i]}});
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_edit_en_nxt    = r_edit_en;
    w_lock_nxt       = r_lock;
    w_cfg_q_nxt      = r_cfg_q;
    w_td_ref_nxt     = r_td_ref;
    w_ch_q_nxt       = r_ch_q;
    w_read_valid_nxt = 1'b0;
    w_pend_nxt       = (r_state == ST_IDLE) ? 1'b0 : (r_pend | w_tick);
    if (w_timeout) begin
      w_state_nxt   = ST_IDLE;
      w_edit_en_nxt = '0;
      w_lock_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_tick || r_pend) w_state_nxt = ST_READ;
          else                  w_state_nxt = ST_IDLE;
        end
        ST_READ: begin
          if (w_ack) begin
            w_state_nxt      = ST_CHECK;
            w_read_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_READ;
          end
        end
        ST_CHECK: begin
          w_td_ref_nxt = timer_done;
          if ((cfg_vec != r_cfg_q) || (timer_done && !r_td_ref)) begin
            w_cfg_q_nxt = cfg_vec;
            w_state_nxt = ST_INIT;
          end else if (w_prog_any && !r_lock) begin
            w_lock_nxt  = 1'b1;
            w_state_nxt = ST_INIT;
          end else if (timer_done && !timer_run) begin
            w_state_nxt = ST_TRESTART;
          end else if (r_lock && w_prog_any) begin
            w_ch_q_nxt    = w_low_ch;
            w_edit_en_nxt = w_low_oh;
            w_state_nxt   = ST_EDIT;
          end else begin
            // Also closes a session whose requests vanished before EDIT.
            w_lock_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_INIT, ST_TRESTART: begin
          if (w_ack) w_state_nxt = ST_READ;
          else       w_state_nxt = r_state;
        end
        ST_EDIT: begin
          if (!prog_req[r_ch_q]) w_state_nxt = ST_SAVE;
          else                   w_state_nxt = ST_EDIT;
        end
        ST_SAVE: begin
          if (w_ack) begin
            w_edit_en_nxt = '0;
            w_lock_nxt    = 1'b0;
            w_state_nxt   = ST_READ;
          end else begin
            w_state_nxt = ST_SAVE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    case (w_state_nxt)
      ST_READ:     begin w_bus_state = 1'b1; w_bus_op_nxt = OP_READ;     end
      ST_INIT:     begin w_bus_state = 1'b1; w_bus_op_nxt = OP_INIT;     end
      ST_TRESTART: begin w_bus_state = 1'b1; w_bus_op_nxt = OP_TRESTART; end
      ST_SAVE:     begin w_bus_state = 1'b1; w_bus_op_nxt = OP_WRITE;    end
      default:     begin w_bus_state = 1'b0; w_bus_op_nxt = OP_READ;     end
    endcase
    // An acked request always drops for one cycle, even when the next state is a bus state.
    w_bus_req_nxt = w_bus_state & ~w_ack;
    w_bus_ch_nxt  = (w_state_nxt == ST_SAVE) ? w_ch_q_nxt : '0;
    w_busy_nxt    = (w_state_nxt != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_bus_req    <= 1'b0;
      r_bus_op     <= 2'd0;
      r_bus_ch     <= '0;
      r_edit_en    <= '0;
      r_lock       <= 1'b0;
      r_read_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_pend       <= 1'b0;
      r_cfg_q      <= '0;
      r_td_ref     <= 1'b0;
      r_ch_q       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_bus_req    <= w_bus_req_nxt;
      r_bus_op     <= w_bus_op_nxt;
      r_bus_ch     <= w_bus_ch_nxt;
      r_edit_en    <= w_edit_en_nxt;
      r_lock       <= w_lock_nxt;
      r_read_valid <= w_read_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_pend       <= w_pend_nxt;
      r_cfg_q      <= w_cfg_q_nxt;
      r_td_ref     <= w_td_ref_nxt;
      r_ch_q       <= w_ch_q_nxt;
    end
  end

`ifdef RTC_SEQ_TIMEOUT_EN
  localparam int TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [TOW-1:0] r_to_cnt;
  logic           r_err;

  assign w_timeout = r_bus_req & ~bus_ack & (r_to_cnt == TOW'(TIMEOUT - 1));

  // Watchdog on the outstanding request; err is sticky until reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_bus_req && !w_ack && !w_timeout) r_to_cnt <= r_to_cnt + TOW'(1);
      else                                    r_to_cnt <= '0;
      if (w_timeout) r_err <= 1'b1;
      else           r_err <= r_err;
    end
  end

  assign err = r_err;
`else
  localparam int unused_timeout = TIMEOUT;
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  assign bus_req    = r_bus_req;
  assign bus_op     = r_bus_op;
  assign bus_ch     = r_bus_ch;
  assign edit_en    = r_edit_en;
  assign lock       = r_lock;
  assign read_valid = r_read_valid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_rtc_sequencer.sv
// Self-checking bench for rtc_sequencer: bus responder, op scoreboard, vector table, corner sequences.
module tb_rtc_sequencer;
  import rtc_seq_pkg::*;

  localparam int NCH = 3;
  localparam int CHW = 2;
  localparam int BOUND = 400;

  logic           clock;
  logic           reset;
  logic [NCH-1:0] prog_req;
  logic [1:0]     cfg_vec;
  logic           timer_done, timer_run, bus_ack;
  logic           bus_req;
  logic [1:0]     bus_op;
  logic [CHW-1:0] bus_ch;
  logic [NCH-1:0] edit_en;
  logic           lock, read_valid, busy, err;

  rtc_sequencer #(.NCH(NCH), .POLL_DIV(16), .CFG_W(2), .TIMEOUT(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .prog_req   (prog_req),
    .cfg_vec    (cfg_vec),
    .timer_done (timer_done),
    .timer_run  (timer_run),
    .bus_ack    (bus_ack),
    .bus_req    (bus_req),
    .bus_op     (bus_op),
    .bus_ch     (bus_ch),
    .edit_en    (edit_en),
    .lock       (lock),
    .read_valid (read_valid),
    .busy       (busy),
    .err        (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] ch;
  } sb_t;

  typedef struct {
    logic [1:0] cfg;
    logic       td;
    logic       tr;
    int         n;
    logic [1:0] ops [0:2];
  } vec_t;

  sb_t  sb_q [$];
  vec_t vecs [0:6];

  int         n_checks = 0;
  int         n_fail   = 0;
  logic       mon_en   = 1'b0;
  logic       ack_en   = 1'b1;
  int         ack_cnt  = 0;
  logic       prev_bus_req = 1'b0;
  logic [1:0] prev_op = 2'd0, held_op = 2'd0;
  logic [1:0] prev_ch = 2'd0, held_ch = 2'd0;
  int         hi_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_op(input logic [1:0] op, input logic [1:0] ch);
    sb_t e;
    e.op = op;
    e.ch = ch;
    sb_q.push_back(e);
  endtask

  task automatic monitor();
    logic exp_rv;
    sb_t  e;
    exp_rv = prev_bus_req && bus_ack && (prev_op == OP_READ);
    if (exp_rv || read_valid) chk("read_valid", 32'(read_valid), 32'(exp_rv));
    if (prev_bus_req && bus_ack) chk("bus_hold", {28'd0, prev_op, prev_ch}, {28'd0, held_op, held_ch});
    if (bus_req && !prev_bus_req) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
      end else begin
        e.op = OP_READ;
        e.ch = 2'd0;
      end
      chk("bus_op", 32'(bus_op), 32'(e.op));
      chk("bus_ch", 32'(bus_ch), 32'(e.ch));
      held_op = bus_op;
      held_ch = bus_ch;
    end
    prev_bus_req = bus_req;
    prev_op      = bus_op;
    prev_ch      = bus_ch;
  endtask

  task automatic respond();
    if (bus_ack) begin
      bus_ack = 1'b0;
      ack_cnt = 0;
    end else if (bus_req && ack_en) begin
      ack_cnt++;
      if (ack_cnt >= 2) bus_ack = 1'b1;
    end else begin
      ack_cnt = 0;
    end
  endtask

  task automatic step();
    @(negedge clock);
    if (mon_en) monitor();
    respond();
  endtask

  function automatic logic cond(input int which);
    case (which)
      0:       return (sb_q.size() == 0) && !busy;
      1:       return edit_en != '0;
      2:       return lock;
      3:       return bus_req && (bus_op == OP_TRESTART);
      4:       return bus_req && (bus_op == OP_WRITE);
      default: return bus_req;
    endcase
  endfunction

  task automatic wait_for(input int which, input string name);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!cond(which) && k < BOUND);
    if (!cond(which)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: event not seen, required within %0d cycles", name, BOUND);
    end
  endtask

  task automatic apply_reset(input int cycles);
    mon_en       = 1'b0;
    reset        = 1'b0;
    sb_q.delete();
    for (int i = 0; i < cycles; i++) step();
    chk("reset_outputs", {18'd0, bus_req, bus_op, bus_ch, edit_en, lock, read_valid, busy, err}, 32'd0);
    reset        = 1'b1;
    prev_bus_req = 1'b0;
    mon_en       = 1'b1;
  endtask

  initial begin
    reset = 1'b0; prog_req = '0; cfg_vec = 2'd0;
    timer_done = 1'b0; timer_run = 1'b0; bus_ack = 1'b0;

    vecs[0] = '{cfg: 2'd2, td: 1'b0, tr: 1'b0, n: 3, ops: '{OP_READ, OP_INIT, OP_READ}};
    vecs[1] = '{cfg: 2'd2, td: 1'b0, tr: 1'b0, n: 1, ops: '{OP_READ, OP_READ, OP_READ}};
    vecs[2] = '{cfg: 2'd2, td: 1'b1, tr: 1'b1, n: 3, ops: '{OP_READ, OP_INIT, OP_READ}};
    vecs[3] = '{cfg: 2'd2, td: 1'b0, tr: 1'b0, n: 1, ops: '{OP_READ, OP_READ, OP_READ}};
    vecs[4] = '{cfg: 2'd1, td: 1'b0, tr: 1'b0, n: 3, ops: '{OP_READ, OP_INIT, OP_READ}};
    vecs[5] = '{cfg: 2'd3, td: 1'b1, tr: 1'b1, n: 3, ops: '{OP_READ, OP_INIT, OP_READ}};
    vecs[6] = '{cfg: 2'd3, td: 1'b0, tr: 1'b1, n: 1, ops: '{OP_READ, OP_READ, OP_READ}};

    // First poll lands exactly POLL_DIV edges after reset release.
    apply_reset(4);
    for (int i = 0; i < 15; i++) step();
    chk("first_req_early", 32'(bus_req), 32'd0);
    step();
    chk("first_req_at_16", 32'(bus_req), 32'd1);
    wait_for(0, "first_read_idle");
    chk("idle_after_read", 32'(busy), 32'd0);

    for (int v = 0; v < 7; v++) begin
      cfg_vec    = vecs[v].cfg;
      timer_done = vecs[v].td;
      timer_run  = vecs[v].tr;
      for (int j = 0; j < vecs[v].n; j++) exp_op(vecs[v].ops[j], 2'd0);
      wait_for(0, "vec_idle");
      chk("vec_lock", 32'(lock), 32'd0);
      chk("vec_edit_en", 32'(edit_en), 32'd0);
    end

    // Timer done with alarm idle: rise re-inits, then TRESTART on the following check.
    timer_done = 1'b1; timer_run = 1'b0;
    exp_op(OP_READ, 2'd0); exp_op(OP_INIT, 2'd0); exp_op(OP_READ, 2'd0);
    exp_op(OP_TRESTART, 2'd0); exp_op(OP_READ, 2'd0);
    wait_for(3, "trestart_seen");
    timer_done = 1'b0;
    wait_for(0, "trestart_idle");
    chk("trestart_drained", 32'(sb_q.size()), 32'd0);

    // Edit session on channel 1 with channel 2 also requesting.
    prog_req = 3'b110;
    exp_op(OP_READ, 2'd0); exp_op(OP_INIT, 2'd0); exp_op(OP_READ, 2'd0);
    wait_for(1, "edit_enter");
    chk("edit_en_ch1", 32'(edit_en), 32'b010);
    chk("edit_lock", 32'(lock), 32'd1);
    prog_req = 3'b111;
    for (int i = 0; i < 5; i++) step();
    chk("edit_ignores_other", 32'(edit_en), 32'b010);
    prog_req = 3'b000;
    exp_op(OP_WRITE, 2'd1); exp_op(OP_READ, 2'd0);
    wait_for(0, "save_idle");
    chk("save_lock_clear", 32'(lock), 32'd0);
    chk("save_edit_clear", 32'(edit_en), 32'd0);

    // Request withdrawn before EDIT: next check closes the session.
    prog_req = 3'b001;
    exp_op(OP_READ, 2'd0); exp_op(OP_INIT, 2'd0); exp_op(OP_READ, 2'd0);
    wait_for(2, "abort_lock_set");
    prog_req = 3'b000;
    wait_for(0, "abort_idle");
    chk("abort_lock_clear", 32'(lock), 32'd0);
    chk("abort_edit_en", 32'(edit_en), 32'd0);

    // Reset in the middle of a SAVE write.
    prog_req = 3'b010;
    exp_op(OP_READ, 2'd0); exp_op(OP_INIT, 2'd0); exp_op(OP_READ, 2'd0);
    wait_for(1, "rst_edit_enter");
    chk("rst_edit_en", 32'(edit_en), 32'b010);
    prog_req = 3'b000;
    exp_op(OP_WRITE, 2'd1);
    wait_for(4, "rst_save_req");
    mon_en = 1'b0;
    reset  = 1'b0;
    step();
    chk("rst_mid_bus_req", 32'(bus_req), 32'd0);
    chk("rst_mid_lock", 32'(lock), 32'd0);
    chk("rst_mid_edit_en", 32'(edit_en), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    apply_reset(2);
    // cfg_q restarts at zero, so the held nonzero cfg_vec forces an INIT.
    exp_op(OP_READ, 2'd0); exp_op(OP_INIT, 2'd0); exp_op(OP_READ, 2'd0);
    wait_for(0, "post_reset_idle");
    chk("post_reset_drained", 32'(sb_q.size()), 32'd0);

`ifdef RTC_SEQ_TIMEOUT_EN
    chk("err_before_timeout", 32'(err), 32'd0);
    ack_en = 1'b0;
    wait_for(5, "timeout_req");
    hi_cnt = 0;
    while (bus_req && hi_cnt < 50) begin
      hi_cnt++;
      step();
    end
    chk("timeout_req_cycles", 32'(hi_cnt), 32'd8);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_idle", 32'(busy), 32'd0);
    ack_en = 1'b1;
`else
    chk("err_tied_low", 32'(err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
